// File: rtl/branch_resolve_unit.sv
// Branch resolution: turns the oldest in-flight mispredict into a squash pulse plus a
// held fetch redirect, and queues every resolved control instruction for predictor training.
module branch_resolve_unit #(
  parameter int SIZE_PC     = 32,
  parameter int SIZE_AL_LOG = 7,
  parameter int UPD_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctrlValid_i,
  input  logic [SIZE_PC-1:0]     pc_i,
  input  logic [SIZE_PC-1:0]     nextPC_i,
  input  logic                   direction_i,
  input  logic [7:0]             flags_i,
  input  logic [SIZE_AL_LOG-1:0] tag_i,
  input  logic [SIZE_AL_LOG-1:0] alHead_i,
  input  logic                   redirectAck_i,
  input  logic                   recoveryDone_i,
  input  logic                   updReady_i,
  output logic                   redirectValid_o,
  output logic [SIZE_PC-1:0]     redirectPC_o,
  output logic                   squash_o,
  output logic [SIZE_AL_LOG-1:0] squashTag_o,
  output logic                   busy_o,
  output logic                   updValid_o,
  output logic [SIZE_PC-1:0]     updPC_o,
  output logic [SIZE_PC-1:0]     updTarget_o,
  output logic                   updDir_o,
  output logic                   full_o,
  output logic [7:0]             drops_o
);

  localparam int IDX_W = $clog2(UPD_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = 2 * SIZE_PC + 1;

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_RECOVER} state_e;

  state_e                 state_q, state_d;
  logic [SIZE_AL_LOG-1:0] ptag_q, ptag_d;
  logic [SIZE_PC-1:0]     ppc_q, ppc_d;
  logic                   squash_q, squash_d;

  logic [SIZE_AL_LOG-1:0] age_in, age_p;
  logic                   misp_in, older_in;
  logic                   unused_flags;

  // Ages are distances from the active-list head, so ordering survives tag wrap.
  assign age_in       = tag_i - alHead_i;
  assign age_p        = ptag_q - alHead_i;
  assign misp_in      = ctrlValid_i & flags_i[0] & flags_i[5];
  assign older_in     = age_in < age_p;
  assign unused_flags = ^{flags_i[7:6], flags_i[4:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptag_q   <= '0;
      ppc_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptag_q   <= ptag_d;
      ppc_q    <= ppc_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptag_d   = ptag_q;
    ppc_d    = ppc_q;
    squash_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (misp_in) begin
          ptag_d   = tag_i;
          ppc_d    = nextPC_i;
          squash_d = 1'b1;
          state_d  = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // An older mispredict wins over a same-cycle acknowledge of the stale target.
        if (misp_in && older_in) begin
          ptag_d   = tag_i;
          ppc_d    = nextPC_i;
          squash_d = 1'b1;
        end else if (redirectAck_i) begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (misp_in && older_in) begin
          ptag_d   = tag_i;
          ppc_d    = nextPC_i;
          squash_d = 1'b1;
          state_d  = S_REDIRECT;
        end else if (recoveryDone_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign redirectValid_o = (state_q == S_REDIRECT);
  assign redirectPC_o    = ppc_q;
  assign squash_o        = squash_q;
  assign squashTag_o     = ptag_q;
  assign busy_o          = (state_q != S_IDLE);

  logic [ENT_W-1:0] mem_q [UPD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]       drops_q;
  logic             empty, full, push, pop, accept, drop;
  logic [ENT_W-1:0] head;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  // Results younger than the pending mispredict are wrong-path and never train.
  assign push   = ctrlValid_i & flags_i[5] & ~(busy_o && (age_in > age_p));
  assign pop    = ~empty & updReady_i;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drops_q  <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= {pc_i, nextPC_i, direction_i};
        wr_ptr_q                   <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop && (drops_q != 8'hFF)) drops_q <= drops_q + 8'd1;
    end
  end

  assign head        = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign updValid_o  = ~empty;
  assign updPC_o     = head[ENT_W-1 -: SIZE_PC];
  assign updTarget_o = head[SIZE_PC:1];
  assign updDir_o    = head[0];
  assign full_o      = full;
  assign drops_o     = drops_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic, scored against
// a queue-based reference model of the redirect protocol and training FIFO.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_valid = 1'b0, direction = 1'b0;
  logic [31:0] pc = '0, next_pc = '0;
  logic [7:0]  flags = '0;
  logic [6:0]  tag = '0, al_head = '0;
  logic        redirect_ack = 1'b0, recovery_done = 1'b0, upd_ready = 1'b0;

  logic        redirect_valid, squash, busy, upd_valid, upd_dir, full;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [6:0]  squash_tag;
  logic [7:0]  drops;

  branch_resolve_unit #(.SIZE_PC(32), .SIZE_AL_LOG(7), .UPD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .ctrlValid_i(ctrl_valid), .pc_i(pc), .nextPC_i(next_pc),
    .direction_i(direction), .flags_i(flags), .tag_i(tag), .alHead_i(al_head),
    .redirectAck_i(redirect_ack), .recoveryDone_i(recovery_done), .updReady_i(upd_ready),
    .redirectValid_o(redirect_valid), .redirectPC_o(redirect_pc), .squash_o(squash),
    .squashTag_o(squash_tag), .busy_o(busy), .updValid_o(upd_valid), .updPC_o(upd_pc),
    .updTarget_o(upd_target), .updDir_o(upd_dir), .full_o(full), .drops_o(drops)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic [31:0] rpc;
    logic        sq;
    logic [6:0]  stag;
    logic        busy;
    logic        uv;
    logic        full;
    logic [7:0]  drops;
  } snap_t;

  snap_t       exp_q[$];
  logic [64:0] upd_q[$];
  logic [6:0]  squash_q[$];
  snap_t       mon_s;
  logic [64:0] mon_e;
  logic [6:0]  mon_t;
  bit          mon_en = 1'b0;
  int          checks = 0, errors = 0;

  // Reference model: a pending redirect (possibly already acknowledged) and an occupancy count.
  bit          m_pend, m_acked, m_sq;
  logic [6:0]  m_ptag;
  logic [31:0] m_ppc;
  int          m_cnt, m_drops;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int age(input logic [6:0] t, input logic [6:0] h);
    return (int'(t) - int'(h) + 128) % 128;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_acked = 0; m_sq = 0; m_ptag = '0; m_ppc = '0; m_cnt = 0; m_drops = 0;
  endtask

  function automatic snap_t mk_snap();
    snap_t s;
    s.rv = m_pend && !m_acked; s.rpc = m_ppc; s.sq = m_sq; s.stag = m_ptag;
    s.busy = m_pend; s.uv = (m_cnt > 0); s.full = (m_cnt == DEPTH);
    s.drops = 8'(m_drops);
    return s;
  endfunction

  task automatic step_model();
    bit misp, ctl, older, pop, wrong;
    if (rst) begin model_reset(); return; end
    misp  = ctrl_valid && flags[0] && flags[5];
    ctl   = ctrl_valid && flags[5];
    older = age(tag, al_head) < age(m_ptag, al_head);
    wrong = m_pend && (age(tag, al_head) > age(m_ptag, al_head));
    pop   = (m_cnt > 0) && upd_ready;
    if (ctl && !wrong) begin
      if (m_cnt == DEPTH && !pop) begin
        if (m_drops < 255) m_drops++;
      end else begin
        upd_q.push_back({pc, next_pc, direction});
        m_cnt++;
      end
    end
    if (pop) m_cnt--;
    m_sq = 0;
    if (misp && (!m_pend || older)) begin
      m_pend = 1; m_acked = 0; m_ptag = tag; m_ppc = next_pc; m_sq = 1;
      squash_q.push_back(tag);
    end else if (m_pend && !m_acked && redirect_ack) begin
      m_acked = 1;
    end else if (m_pend && m_acked && recovery_done) begin
      m_pend = 0;
    end
  endtask

  // One clock: score the inputs the DUT just sampled, then release the bench to drive anew.
  task automatic cycle();
    @(posedge clk);
    step_model();
    exp_q.push_back(mk_snap());
    #1;
  endtask

  task automatic set_idle();
    ctrl_valid = 0; flags = '0; redirect_ack = 0; recovery_done = 0;
  endtask

  task automatic set_ctl(input logic [6:0] t, input logic [31:0] npc, input bit misp);
    ctrl_valid = 1; pc = $urandom; next_pc = npc; direction = 1'($urandom_range(0, 1));
    flags = misp ? 8'hA5 : 8'h20; tag = t;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rv"}, 96'(redirect_valid), 96'(0));
    chk({pfx, "_rpc"}, 96'(redirect_pc), 96'(0));
    chk({pfx, "_sq"}, 96'(squash), 96'(0));
    chk({pfx, "_stag"}, 96'(squash_tag), 96'(0));
    chk({pfx, "_busy"}, 96'(busy), 96'(0));
    chk({pfx, "_uv"}, 96'(upd_valid), 96'(0));
    chk({pfx, "_upc"}, 96'({upd_pc, upd_target, upd_dir}), 96'(0));
    chk({pfx, "_full"}, 96'(full), 96'(0));
    chk({pfx, "_drops"}, 96'(drops), 96'(0));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) chk("snap_underflow", 96'(0), 96'(1));
      else begin
        mon_s = exp_q.pop_front();
        chk("redirect_valid", 96'(redirect_valid), 96'(mon_s.rv));
        chk("redirect_pc", 96'(redirect_pc), 96'(mon_s.rpc));
        chk("squash", 96'(squash), 96'(mon_s.sq));
        chk("squash_tag", 96'(squash_tag), 96'(mon_s.stag));
        chk("busy", 96'(busy), 96'(mon_s.busy));
        chk("upd_valid", 96'(upd_valid), 96'(mon_s.uv));
        chk("full", 96'(full), 96'(mon_s.full));
        chk("drops", 96'(drops), 96'(mon_s.drops));
      end
      if (squash) begin
        if (squash_q.size() == 0) chk("squash_extra", 96'(1), 96'(0));
        else begin
          mon_t = squash_q.pop_front();
          chk("squash_event_tag", 96'(squash_tag), 96'(mon_t));
        end
      end
      if (upd_valid && upd_ready) begin
        if (upd_q.size() == 0) chk("upd_extra", 96'(1), 96'(0));
        else begin
          mon_e = upd_q.pop_front();
          chk("upd_entry", 96'({upd_pc, upd_target, upd_dir}), 96'(mon_e));
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cycle();
    mon_en = 1;

    // Single mispredict with exact redirect/recovery timing.
    al_head = 0; upd_ready = 0; set_idle();
    repeat (2) cycle();
    set_ctl(7'd10, 32'h0040_0100, 1);
    cycle(); set_idle();
    chk("s1_squash", 96'(squash), 96'(1));
    chk("s1_stag", 96'(squash_tag), 96'(10));
    chk("s1_rpc", 96'(redirect_pc), 96'(32'h0040_0100));
    cycle();
    chk("s1_squash_once", 96'(squash), 96'(0));
    repeat (2) cycle();
    redirect_ack = 1;
    cycle(); redirect_ack = 0;
    chk("s1_rv_drop", 96'(redirect_valid), 96'(0));
    repeat (2) cycle();
    recovery_done = 1;
    cycle(); recovery_done = 0;
    chk("s1_busy_fall", 96'(busy), 96'(0));
    chk("s1_one_entry", 96'(upd_valid), 96'(1));
    upd_ready = 1;
    repeat (2) cycle();

    // Older override across tag wrap; a later younger mispredict is ignored.
    al_head = 7'd120;
    set_ctl(7'd3, 32'h1111_0000, 1); cycle(); set_idle(); cycle();
    set_ctl(7'd125, 32'h2222_0000, 1); cycle();
    chk("s2_squash", 96'(squash), 96'(1));
    chk("s2_stag", 96'(squash_tag), 96'(125));
    chk("s2_rpc", 96'(redirect_pc), 96'(32'h2222_0000));
    set_ctl(7'd5, 32'h3333_0000, 1); cycle(); set_idle();
    chk("s2_ignore_rpc", 96'(redirect_pc), 96'(32'h2222_0000));
    redirect_ack = 1; cycle(); set_idle(); cycle();
    recovery_done = 1; cycle(); set_idle(); cycle();

    // Older mispredict in the same cycle as the acknowledge.
    al_head = 0;
    set_ctl(7'd20, 32'h4444_0000, 1); cycle(); set_idle(); cycle();
    set_ctl(7'd15, 32'h5555_0000, 1); redirect_ack = 1; cycle(); set_idle();
    chk("s3_rv_held", 96'(redirect_valid), 96'(1));
    chk("s3_rpc", 96'(redirect_pc), 96'(32'h5555_0000));
    chk("s3_squash", 96'(squash), 96'(1));
    redirect_ack = 1; cycle(); set_idle();
    recovery_done = 1; cycle(); set_idle(); repeat (2) cycle();

    // Training FIFO fill, drops, and push+pop while full.
    upd_ready = 0;
    for (int i = 0; i < 6; i++) begin
      set_ctl(7'(i), $urandom, 0); cycle();
      if (i == 3) chk("s4_full_at4", 96'(full), 96'(1));
    end
    set_idle();
    chk("s4_drops", 96'(drops), 96'(2));
    set_ctl(7'd50, 32'h6666_0000, 0); upd_ready = 1; cycle(); set_idle();
    chk("s5_full_kept", 96'(full), 96'(1));
    chk("s5_drops_kept", 96'(drops), 96'(2));
    repeat (6) cycle();

    // Wrong-path filter, then reset in the middle of a redirect.
    upd_ready = 0;
    set_ctl(7'd10, 32'h7777_0000, 1); cycle();
    set_ctl(7'd12, 32'h8888_0000, 0); cycle(); set_idle();
    #1 rst = 1;
    #1 chk_all_zero("midreset");
    model_reset();
    exp_q.delete(); upd_q.delete(); squash_q.delete();
    exp_q.push_back(mk_snap());
    cycle(); rst = 0; upd_ready = 1;
    repeat (3) cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      bit v, c;
      v = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) al_head = al_head + 7'($urandom_range(1, 3));
      ctrl_valid = v; pc = $urandom; next_pc = $urandom;
      direction = 1'($urandom_range(0, 1));
      flags = 8'($urandom);
      flags[5] = c;
      flags[0] = ($urandom_range(0, 4) == 0);
      tag = al_head + 7'($urandom_range(0, 20));
      redirect_ack = ($urandom_range(0, 3) == 0);
      recovery_done = ($urandom_range(0, 3) == 0);
      upd_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    set_idle(); upd_ready = 1;
    repeat (10) cycle();
    @(negedge clk); #1;
    mon_en = 0;
    chk("end_upd_q_empty", 96'(upd_q.size()), 96'(0));
    chk("end_squash_q_empty", 96'(squash_q.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Receives resolved control-instruction results from the execute-stage control ALU and acts on them. It turns the oldest in-flight mispredict into a held fetch redirect and a one-cycle squash pulse, then waits out pipeline recovery. Every resolved control instruction also goes into a small FIFO of predictor training updates drained by the branch predictor/BTB. It sits between the execute stage's control lane and fetch/branch-prediction.

## Interface

- SIZE_PC, 32, PC/target width
- SIZE_AL_LOG, 7, active-list index width (branch tag)
- UPD_DEPTH, 4, training FIFO entries (power of 2, ≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- ctrlValid_i  in  1  control ALU result valid this cycle
- pc_i  in  SIZE_PC  PC of resolved instruction
- nextPC_i  in  SIZE_PC  resolved next PC
- direction_i  in  1  resolved taken/not-taken
- flags_i  in  8  execution flags; [0]=mispredict, [5]=control instruction
- tag_i  in  SIZE_AL_LOG  active-list index of resolved instruction
- alHead_i  in  SIZE_AL_LOG  current active-list head (oldest)
- redirectAck_i  in  1  fetch accepted redirect
- recoveryDone_i  in  1  pipeline recovery complete
- updReady_i  in  1  predictor accepts update
- redirectValid_o  out  1  redirect request, held until acked
- redirectPC_o  out  SIZE_PC  redirect target
- squash_o  out  1  one-cycle squash pulse
- squashTag_o  out  SIZE_AL_LOG  tag of mispredicting branch; younger instructions are squashed
- busy_o  out  1  state ≠ IDLE
- updValid_o  out  1  FIFO non-empty
- updPC_o  out  SIZE_PC  head entry PC
- updTarget_o  out  SIZE_PC  head entry nextPC
- updDir_o  out  1  head entry direction
- full_o  out  1  FIFO full
- drops_o  out  8  saturating count of dropped updates

## Operation

- age(t) = (t − alHead_i) mod 2^SIZE_AL_LOG. Smaller age means older. An equal tag is not older.
- mispIn = ctrlValid_i & flags_i[0] & flags_i[5].
- The FSM has three states: IDLE, REDIRECT, RECOVER. Pending registers are pTag and pPC.
- IDLE: on mispIn, latch pTag=tag_i and pPC=nextPC_i, pulse squash, go to REDIRECT.
- REDIRECT:
  - A mispIn with age(tag_i) < age(pTag) replaces pTag/pPC, pulses squash again, and stays in REDIRECT. This takes priority over a same-cycle redirectAck_i.
  - Otherwise redirectAck_i moves the FSM to RECOVER.
  - A younger or equal mispIn is ignored.
- RECOVER:
  - An older mispIn replaces pTag/pPC, pulses squash, and returns to REDIRECT. This takes priority over recoveryDone_i.
  - Otherwise recoveryDone_i moves the FSM to IDLE.
- Output mapping: redirectValid_o = (state==REDIRECT), redirectPC_o = pPC, squashTag_o = pTag.
- Training push condition: ctrlValid_i & flags_i[5].
  - Discarded (not pushed, not counted) when state≠IDLE and age(tag_i) > age(pTag). These are wrong-path results.
  - The mispredicting branch itself is always pushed.
- Push stores {pc_i, nextPC_i, direction_i}.
- Pop occurs when updValid_o & updReady_i. Head data is driven from registered storage.
- Pointers are log2(UPD_DEPTH)+1 bits wide with a wrap bit. full = same index, different wrap bit.
- Push while full with no same-cycle pop: the entry is dropped and drops_o increments, saturating at 255.
- Push while full with a same-cycle pop: the push is accepted.
- Push and pop together when empty: no bypass. The pushed entry becomes visible next cycle.

## Timing

- Reset: state=IDLE; pTag, pPC, FIFO pointers and drops_o = 0. All outputs are 0.
- mispIn at cycle N:
  - squash_o=1 during N+1 only.
  - redirectValid_o=1 and redirectPC_o valid from N+1.
- redirectValid_o stays high and stable until the cycle redirectAck_i is sampled high; it drops the following cycle. The one exception is an older replacement, which changes redirectPC_o while the request is held.
- busy_o rises at N+1 and falls the cycle after recoveryDone_i is sampled in RECOVER.
- Push at cycle N: updValid_o rises at N+1. full_o and drops_o update at N+1.
- Reset asserted mid-redirect or mid-recovery: immediate return to the reset values. No squash is emitted after reset releases.

## Test plan

- **Single mispredict:** alHead=0; at cycle 5 drive tag=10, nextPC=0x400100, flags=0xA5. Required:
  - squash_o pulses exactly at cycle 6 with squashTag=10.
  - redirectValid_o is held with 0x400100 until ack at cycle 9, then low at 10.
  - recoveryDone at 12 → busy_o low at 13.
  - The FIFO holds one entry.
- **Older override across wrap:** alHead=120; mispredict tag=3, then tag=125 two cycles later during REDIRECT. Required: second squash with squashTag=125 and redirectPC replaced. A later mispredict with tag=5 is ignored.
- **Override vs ack same cycle:** an older mispredict arrives in the same cycle as redirectAck_i. Required: the FSM stays in REDIRECT with the new target, and a new squash pulse is emitted.
- **FIFO full:** UPD_DEPTH=4, updReady=0, six pushes. Required: full_o high after the 4th push, drops_o=2, and entries pop in push order once ready.
- **Full with simultaneous push and pop:** the push is accepted, drops_o is unchanged, and full_o stays 1.
- **Wrong-path filter and reset:** while pTag=10 and alHead=0, a control result with tag=12 is not pushed and not counted. Assert reset mid-REDIRECT: all outputs are 0 in the same cycle, and there is no squash after release.
